// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_rr_arbiter_if: request/data/grant bundle of the shared 1-bit mux path. Rev 1.0
// ----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int SELW = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel;
  logic            dout;
  logic            dout_vld;
  logic            busy;

  // Requester side drives req/din and observes the arbitration result.
  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  dout,
    input  dout_vld,
    input  busy
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output dout,
    output dout_vld,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_rr_arbiter: round-robin grant of one shared 1-bit mux line, hold-capped. Rev 1.0
// ----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int SELW     = 2,
  parameter int MAX_HOLD = 4,
  parameter int CNTW     = 2
) (
  input wire              clk,
  input wire              rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);
  localparam logic [SELW-1:0] PTR_RST   = SELW'(NREQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

  logic [SELW-1:0] pick_base;
  logic [SELW-1:0] pick_cand;
  logic [SELW-1:0] pick_idx;
  logic            pick_vld;
  logic            release_grant;
  logic            grant_live;

  // Scan base: the last winner, so the scan starts just after it.
  always_comb begin
    pick_base = (state_q == S_GRANT) ? sel_q : ptr_q;
  end

  // Descending loop so the nearest candidate after the base is assigned last and wins.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      pick_cand = pick_base + SELW'(k);
      if (bus.req[pick_cand]) begin
        pick_vld = 1'b1;
        pick_idx = pick_cand;
      end
    end
  end

  always_comb begin
    release_grant = !bus.req[sel_q] || (hold_cnt_q == HOLD_LAST);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d           = S_GRANT;
          ptr_d             = pick_idx;
          sel_d             = pick_idx;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          hold_cnt_d        = '0;
        end
      end
      S_GRANT: begin
        if (release_grant) begin
          if (pick_vld) begin
            // Back-to-back hand-over: no idle bubble between grants.
            ptr_d           = pick_idx;
            sel_d           = pick_idx;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            hold_cnt_d      = '0;
          end else begin
            state_d    = S_IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_RST;
      sel_q      <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Data is only valid while the granted requester still asserts req.
  always_comb begin
    grant_live = (state_q == S_GRANT) && bus.req[sel_q];
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q == S_GRANT);
  assign bus.dout_vld = grant_live;
  assign bus.dout     = grant_live & bus.din[sel_q];

endmodule
`default_nettype wire
